// File: rtl/tl_traffic_gen.sv
// tl_traffic_gen: TileLink-UL master traffic generator used for ROM/RAM bring-up.
// It issues periodic Get requests, or PutFullData+Get pairs when WRITE_EN is set, over a
// strided, wrapping address window. It allows several requests in flight at once and checks
// every D-channel response.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tl_a_*            A channel (master drives; a_ready from slave)
//   tl_d_*            D channel (slave drives; d_ready tied high)
//   done_o            NUM_REQ!=0, all beats issued and all responses received (sticky)
//   req_count_o       A beats accepted (saturating)
//   resp_count_o      D beats accepted (saturating)
//   err_count_o       D beats failing any check, at most one per beat (saturating)
module tl_traffic_gen #(
    parameter int unsigned PERIOD          = 256,
    parameter logic [63:0] BASE_ADDR       = 64'd0,
    parameter logic [63:0] LAST_ADDR       = 64'd48,
    parameter logic [63:0] STRIDE          = 64'd8,
    parameter int unsigned MAX_OUTSTANDING = 1,
    parameter bit          WRITE_EN        = 1'b0,
    parameter int unsigned NUM_REQ         = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    // A channel
    output logic        tl_a_valid_o,
    input  logic        tl_a_ready_i,
    output logic [2:0]  tl_a_opcode_o,
    output logic [2:0]  tl_a_param_o,
    output logic [1:0]  tl_a_size_o,
    output logic [3:0]  tl_a_source_o,
    output logic [63:0] tl_a_address_o,
    output logic [7:0]  tl_a_mask_o,
    output logic [63:0] tl_a_data_o,
    output logic        tl_a_corrupt_o,
    // D channel
    input  logic        tl_d_valid_i,
    output logic        tl_d_ready_o,
    input  logic [2:0]  tl_d_opcode_i,
    input  logic [1:0]  tl_d_param_i,
    input  logic [1:0]  tl_d_size_i,
    input  logic [3:0]  tl_d_source_i,
    input  logic        tl_d_sink_i,
    input  logic        tl_d_denied_i,
    input  logic [63:0] tl_d_data_i,
    input  logic        tl_d_corrupt_i,
    // Status
    output logic        done_o,
    output logic [15:0] req_count_o,
    output logic [15:0] resp_count_o,
    output logic [15:0] err_count_o
);

    localparam logic [2:0]  OpPutFull    = 3'd0;
    localparam logic [2:0]  OpGet        = 3'd4;
    localparam logic [2:0]  OpAccessAck  = 3'd0;
    localparam logic [2:0]  OpAccessAckD = 3'd1;

    localparam logic [4:0]  MaxOut     = 5'(MAX_OUTSTANDING);
    localparam logic [3:0]  MaxSrc     = 4'(MAX_OUTSTANDING - 1);
    localparam logic [15:0] NumReq     = 16'(NUM_REQ);
    localparam logic [31:0] PeriodLast = 32'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StWaitRoom} state_e;

    state_e            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic              token_q, token_d;
    logic [63:0]       addr_q, addr_d;
    logic [3:0]        src_q, src_d;
    logic [2:0]        a_opcode_q, a_opcode_d;
    logic [3:0]        a_source_q, a_source_d;
    logic [63:0]       a_address_q, a_address_d;
    logic [63:0]       a_data_q, a_data_d;
    logic [15:0]       inflight_q, inflight_d;
    logic [15:0]       exp_get_q;
    logic [15:0][31:0] exp_addr_q;
    logic [15:0]       req_count_q, req_count_d;
    logic [15:0]       resp_count_q, resp_count_d;
    logic [15:0]       err_count_q, err_count_d;
    logic              done_q, done_d;

    logic [4:0]  outstanding;
    logic        room, num_reached, issue, get_room, a_hs, period_wrap;
    logic        d_src_live, d_exp_get, d_data_bad, d_err;
    logic [2:0]  d_exp_opcode;
    logic [31:0] d_exp_addr;
    logic        unused_d_fields;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    assign unused_d_fields = ^{tl_d_param_i, tl_d_size_i, tl_d_sink_i};

    assign outstanding = popcount16(inflight_q);
    assign room        = (outstanding < MaxOut);
    assign num_reached = (NUM_REQ != 0) && (req_count_q == NumReq);
    assign issue       = (state_q == StIdle) && token_q && room && !num_reached;
    assign get_room    = (state_q == StWaitRoom) && room;
    assign a_hs        = tl_a_valid_o && tl_a_ready_i;
    assign period_wrap = (period_q == PeriodLast);

    // Response check against what was recorded for this source when its A beat went out.
    assign d_src_live   = inflight_q[tl_d_source_i];
    assign d_exp_get    = exp_get_q[tl_d_source_i];
    assign d_exp_addr   = exp_addr_q[tl_d_source_i];
    assign d_exp_opcode = d_exp_get ? OpAccessAckD : OpAccessAck;
    assign d_data_bad   = WRITE_EN && d_exp_get && (tl_d_data_i != {~d_exp_addr, d_exp_addr});
    assign d_err        = tl_d_valid_i && (!d_src_live || (tl_d_opcode_i != d_exp_opcode) ||
                          tl_d_denied_i || tl_d_corrupt_i || d_data_bad);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StAddr;
            end
            StAddr: begin
                if (a_hs) state_d = (a_opcode_q == OpPutFull) ? StWaitRoom : StIdle;
            end
            StWaitRoom: begin
                if (room) state_d = StAddr;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM / channel outputs
    always_comb begin
        tl_a_valid_o   = (state_q == StAddr);
        tl_a_opcode_o  = a_opcode_q;
        tl_a_param_o   = 3'd0;
        tl_a_size_o    = 2'd3;
        tl_a_source_o  = a_source_q;
        tl_a_address_o = a_address_q;
        tl_a_mask_o    = 8'hFF;
        tl_a_data_o    = a_data_q;
        tl_a_corrupt_o = 1'b0;
        tl_d_ready_o   = 1'b1;
        done_o         = done_q;
        req_count_o    = req_count_q;
        resp_count_o   = resp_count_q;
        err_count_o    = err_count_q;
    end

    // Datapath next state
    always_comb begin
        period_d    = period_wrap ? 32'd0 : period_q + 32'd1;
        // A new token overrides consumption in the same cycle; one arriving while pending is lost.
        token_d     = period_wrap || (token_q && !issue);

        a_opcode_d  = a_opcode_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_data_d    = a_data_q;
        if (issue) begin
            a_source_d  = src_q;
            a_address_d = addr_q;
            if (WRITE_EN) begin
                a_opcode_d = OpPutFull;
                a_data_d   = {~addr_q[31:0], addr_q[31:0]};
            end else begin
                a_opcode_d = OpGet;
                a_data_d   = 64'd0;
            end
        end else if (get_room) begin
            a_source_d  = src_q;
            a_address_d = addr_q;
            a_opcode_d  = OpGet;
            a_data_d    = 64'd0;
        end

        addr_d = addr_q;
        src_d  = src_q;
        if (a_hs) begin
            src_d = (src_q == MaxSrc) ? 4'd0 : src_q + 4'd1;
            // Put and Get of a pair share an address; only the Get moves the window on.
            if (a_opcode_q == OpGet) begin
                addr_d = (addr_q >= LAST_ADDR) ? BASE_ADDR : addr_q + STRIDE;
            end
        end

        // Set after clear so a source freed and reissued in one cycle stays in flight.
        inflight_d = inflight_q;
        if (tl_d_valid_i) inflight_d[tl_d_source_i] = 1'b0;
        if (a_hs) inflight_d[a_source_q] = 1'b1;

        req_count_d  = req_count_q;
        resp_count_d = resp_count_q;
        err_count_d  = err_count_q;
        if (a_hs && (req_count_q != 16'hFFFF)) req_count_d = req_count_q + 16'd1;
        if (tl_d_valid_i && (resp_count_q != 16'hFFFF)) resp_count_d = resp_count_q + 16'd1;
        if (d_err && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;

        done_d = done_q || (num_reached && (inflight_q == 16'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q     <= '0;
            token_q      <= 1'b1;
            addr_q       <= BASE_ADDR;
            src_q        <= '0;
            a_opcode_q   <= OpGet;
            a_source_q   <= '0;
            a_address_q  <= '0;
            a_data_q     <= '0;
            inflight_q   <= '0;
            exp_get_q    <= '0;
            exp_addr_q   <= '0;
            req_count_q  <= '0;
            resp_count_q <= '0;
            err_count_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            period_q     <= period_d;
            token_q      <= token_d;
            addr_q       <= addr_d;
            src_q        <= src_d;
            a_opcode_q   <= a_opcode_d;
            a_source_q   <= a_source_d;
            a_address_q  <= a_address_d;
            a_data_q     <= a_data_d;
            inflight_q   <= inflight_d;
            req_count_q  <= req_count_d;
            resp_count_q <= resp_count_d;
            err_count_q  <= err_count_d;
            done_q       <= done_d;
            if (a_hs) begin
                exp_get_q[a_source_q]  <= (a_opcode_q == OpGet);
                exp_addr_q[a_source_q] <= a_address_q[31:0];
            end
        end
    end

endmodule
